// File: rtl/me_search_ctrl.sv
// Full-search motion-estimation sequencer: issues one SAD row command per dy,
// reduces each returned row to a running minimum and publishes the winning vector.
module me_search_ctrl #(
  parameter int SEARCH_R = 8,
  parameter int SAD_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_i,
  input  logic                        abort_i,
  output logic                        cmd_valid_o,
  input  logic                        cmd_ready_i,
  output logic [7:0]                  cmd_dy_o,
  input  logic                        sad_valid_i,
  input  logic [2*SEARCH_R*SAD_W-1:0] sad_results_i,
  output logic                        busy_o,
  output logic                        block_done_o,
  output logic [15:0]                 block_me_o,
  output logic [SAD_W-1:0]            best_sad_o,
  output logic                        err_o
);

  localparam int LANES = 2 * SEARCH_R;
  localparam logic signed [7:0] DY_FIRST = 8'(-SEARCH_R);
  localparam logic signed [7:0] DY_LAST  = 8'(SEARCH_R - 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_REDUCE, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic signed [7:0]        row_dy_q, row_dy_d;
  logic [LANES*SAD_W-1:0]   row_q;
  logic [SAD_W-1:0]         run_sad_q, run_sad_d;
  logic [7:0]               run_dx_q, run_dx_d;
  logic [7:0]               run_dy_q, run_dy_d;
  logic [15:0]              block_me_q, block_me_d;
  logic [SAD_W-1:0]         best_sad_q, best_sad_d;
  logic                     err_q, err_d;
  logic                     sample_row;
  logic [SAD_W-1:0]         row_min;
  logic [7:0]               min_idx;
  logic [7:0]               row_dx;
  logic                     take_row;

  // Strict compare while scanning upward keeps the lowest lane on a tie.
  always_comb begin
    row_min = row_q[SAD_W-1:0];
    min_idx = '0;
    for (int i = 1; i < LANES; i++) begin
      if (row_q[SAD_W*i +: SAD_W] < row_min) begin
        row_min = row_q[SAD_W*i +: SAD_W];
        min_idx = 8'(i);
      end
    end
  end

  assign row_dx   = min_idx - 8'(SEARCH_R);
  assign take_row = (row_dy_q == DY_FIRST) || (row_min < run_sad_q);

  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    state_d      = state_q;
    row_dy_d     = row_dy_q;
    run_sad_d    = run_sad_q;
    run_dx_d     = run_dx_q;
    run_dy_d     = run_dy_q;
    block_me_d   = block_me_q;
    best_sad_d   = best_sad_q;
    err_d        = err_q;
    sample_row   = 1'b0;
    cmd_valid_o  = 1'b0;
    block_done_o = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          err_d    = 1'b0;
          row_dy_d = DY_FIRST;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cmd_valid_o = 1'b1;
        if (cmd_ready_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (sad_valid_i) begin
          sample_row = 1'b1;
          state_d    = S_REDUCE;
        end
      end
      S_REDUCE: begin
        if (take_row) begin
          run_sad_d = row_min;
          run_dx_d  = row_dx;
          run_dy_d  = row_dy_q;
        end
        if (row_dy_q == DY_LAST) begin
          block_me_d = {run_dx_d, run_dy_d};
          best_sad_d = run_sad_d;
          state_d    = S_DONE;
        end else begin
          row_dy_d = row_dy_q + 8'sd1;
          state_d  = S_ISSUE;
        end
      end
      S_DONE: begin
        block_done_o = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (sad_valid_i && state_q != S_WAIT) err_d = 1'b1;

    // Abort discards the pass without touching the published result.
    if (abort_i && state_q != S_IDLE) begin
      state_d    = S_IDLE;
      sample_row = 1'b0;
      block_me_d = block_me_q;
      best_sad_d = best_sad_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      row_dy_q   <= '0;
      run_sad_q  <= '0;
      run_dx_q   <= '0;
      run_dy_q   <= '0;
      block_me_q <= '0;
      best_sad_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_dy_q   <= row_dy_d;
      run_sad_q  <= run_sad_d;
      run_dx_q   <= run_dx_d;
      run_dy_q   <= run_dy_d;
      block_me_q <= block_me_d;
      best_sad_q <= best_sad_d;
      err_q      <= err_d;
    end
  end

  // NOTE: the row buffer is pure data, always written before it is read, so it carries no reset.
  always_ff @(posedge clk) begin
    if (sample_row) row_q <= sad_results_i;
  end

  assign cmd_dy_o   = cmd_valid_o ? row_dy_q : 8'h00;
  assign busy_o     = (state_q != S_IDLE);
  assign block_me_o = block_me_q;
  assign best_sad_o = best_sad_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_me_search_ctrl.sv
// Self-checking bench for me_search_ctrl: directed and randomized SAD windows
// compared against a row-major first-minimum reference model.
module tb_me_search_ctrl;

  localparam int R = 8;
  localparam int W = 16;
  localparam int L = 2 * R;

  logic           clk = 1'b0;
  logic           rst;
  logic           start, abort, cmd_ready, sad_valid;
  logic           cmd_valid, busy, block_done, err;
  logic [7:0]     cmd_dy;
  logic [L*W-1:0] sad_results;
  logic [15:0]    block_me;
  logic [W-1:0]   best_sad;

  logic [W-1:0]   tab [L][L];
  int             pass_cnt = 0;
  int             total_cnt = 0;
  int             done_cnt = 0;
  int             hs_cnt = 0;
  logic [15:0]    last_me;
  logic [W-1:0]   last_sad;

  always #5 clk = ~clk;

  me_search_ctrl #(.SEARCH_R(R), .SAD_W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .abort_i      (abort),
    .cmd_valid_o  (cmd_valid),
    .cmd_ready_i  (cmd_ready),
    .cmd_dy_o     (cmd_dy),
    .sad_valid_i  (sad_valid),
    .sad_results_i(sad_results),
    .busy_o       (busy),
    .block_done_o (block_done),
    .block_me_o   (block_me),
    .best_sad_o   (best_sad),
    .err_o        (err)
  );

  always @(posedge clk) begin
    if (block_done) done_cnt <= done_cnt + 1;
    if (cmd_valid && cmd_ready) hs_cnt <= hs_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [L*W-1:0] pack(input int r);
    logic [L*W-1:0] v;
    for (int l = 0; l < L; l++) v[l*W +: W] = tab[r][l];
    return v;
  endfunction

  task automatic fill(input int val);
    for (int r = 0; r < L; r++)
      for (int l = 0; l < L; l++) tab[r][l] = W'(val);
  endtask

  task automatic fill_random(input int hi);
    for (int r = 0; r < L; r++)
      for (int l = 0; l < L; l++) tab[r][l] = W'($urandom_range(0, hi));
  endtask

  // First minimum in scan order dy=-R..R-1, dx=-R..R-1.
  task automatic model(output logic [15:0] me, output logic [W-1:0] s);
    int br = 0;
    int bl = 0;
    for (int r = 0; r < L; r++)
      for (int l = 0; l < L; l++)
        if (tab[r][l] < tab[br][bl]) begin
          br = r;
          bl = l;
        end
    me = {8'(bl - R), 8'(br - R)};
    s  = tab[br][bl];
  endtask

  task automatic run_pass(input int stall, input int abort_row, input bit poke_start, output int lat);
    int n;
    int t;
    logic [7:0] held;
    bit stable;
    stable = 1'b1;
    lat    = -1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 0;
    for (int r = 0; r < L; r++) begin
      t = 0;
      while (!cmd_valid && t < 20) begin
        @(negedge clk);
        n++;
        t++;
      end
      if (!cmd_valid) begin
        check("cmd_timeout", 32'd0, 32'd1);
        return;
      end
      check("cmd_dy", {{24{cmd_dy[7]}}, cmd_dy}, 32'(r - R));
      held = cmd_dy;
      for (int s = 0; s < stall; s++) begin
        cmd_ready = 1'b0;
        start     = poke_start;
        @(negedge clk);
        n++;
        if (!cmd_valid || cmd_dy !== held) stable = 1'b0;
      end
      start     = 1'b0;
      cmd_ready = 1'b1;
      @(negedge clk);
      n++;
      cmd_ready   = 1'b0;
      sad_results = pack(r);
      sad_valid   = 1'b1;
      if (r == abort_row) begin
        abort = 1'b1;
        @(negedge clk);
        abort     = 1'b0;
        sad_valid = 1'b0;
        return;
      end
      @(negedge clk);
      n++;
      sad_valid = 1'b0;
    end
    check("cmd_stable", 32'(stable), 32'd1);
    t = 0;
    while (!block_done && t < 20) begin
      @(negedge clk);
      n++;
      t++;
    end
    if (!block_done) begin
      check("done_timeout", 32'd0, 32'd1);
      return;
    end
    lat = n;
    @(negedge clk);
    check("done_pulse", 32'(block_done), 32'd0);
  endtask

  task automatic full_pass(input int stall, input bit poke_start);
    int lat;
    int d0;
    int h0;
    model(last_me, last_sad);
    d0 = done_cnt;
    h0 = hs_cnt;
    run_pass(stall, -1, poke_start, lat);
    check("block_me", 32'(block_me), 32'(last_me));
    check("best_sad", 32'(best_sad), 32'(last_sad));
    check("latency", 32'(lat), 32'(6 * R + L * stall));
    check("handshakes", 32'(hs_cnt - h0), 32'(L));
    check("done_count", 32'(done_cnt - d0), 32'd1);
    check("err_clear", 32'(err), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int lat;
    int d0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; cmd_ready = 1'b0;
    sad_valid = 1'b0; sad_results = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst_cmd_dy", 32'(cmd_dy), 32'd0);
    check("rst_done", 32'(block_done), 32'd0);
    check("rst_me", 32'(block_me), 32'd0);
    check("rst_sad", 32'(best_sad), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    fill(1000);
    tab[3 + R][3 + R] = 16'd5;
    full_pass(0, 1'b0);
    check("t1_me_const", 32'(block_me), 32'h0303);
    check("t1_sad_const", 32'(best_sad), 32'd5);

    fill(900);
    tab[0][0] = 16'd7;
    tab[2 + R][4] = 16'd7;
    full_pass(0, 1'b0);
    check("xrow_tie_const", 32'(block_me), 32'hF8F8);

    fill(900);
    tab[R][2] = 16'd3;
    tab[R][9] = 16'd3;
    full_pass(0, 1'b0);
    check("inrow_tie_const", 32'(block_me), 32'hFA00);

    fill(16'hFFFF);
    full_pass(0, 1'b0);
    check("ones_me_const", 32'(block_me), 32'hF8F8);
    check("ones_sad_const", 32'(best_sad), 32'h0000FFFF);

    fill(1000);
    tab[3 + R][3 + R] = 16'd5;
    full_pass(5, 1'b0);
    check("bp_me_const", 32'(block_me), 32'h0303);

    // Abort in WAIT of row dy=-2 together with sad_valid.
    d0 = done_cnt;
    fill_random(50);
    run_pass(0, R - 2, 1'b0, lat);
    check("abort_idle", 32'(busy), 32'd0);
    check("abort_cmd_valid", 32'(cmd_valid), 32'd0);
    repeat (3) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_keep_me", 32'(block_me), 32'(last_me));
    check("abort_keep_sad", 32'(best_sad), 32'(last_sad));
    full_pass(0, 1'b0);

    // Spurious row while idle.
    @(negedge clk) sad_valid = 1'b1;
    sad_results = '0;
    @(negedge clk) sad_valid = 1'b0;
    check("spur_err", 32'(err), 32'd1);
    check("spur_keep_me", 32'(block_me), 32'(last_me));
    check("spur_keep_sad", 32'(best_sad), 32'(last_sad));
    check("spur_idle", 32'(busy), 32'd0);
    fill_random(40);
    full_pass(0, 1'b0);

    for (int k = 0; k < 5; k++) begin
      if (k == 2) fill_random(65535);
      else fill_random(30);
      full_pass(int'($urandom_range(0, 3)), k == 1);
    end

    // Reset in the middle of a pass.
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_me", 32'(block_me), 32'd0);
    check("midrst_sad", 32'(best_sad), 32'd0);
    @(negedge clk) rst = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
